// File: rtl/vga_pkg.sv
// Shared constants for the VGA text-mode read path: screen geometry, font shape and colour width.
package vga_pkg;

  localparam int unsigned H_CHARS      = 80;
  localparam int unsigned V_ROWS       = 25;
  localparam int unsigned TEXT_WORDS   = H_CHARS * V_ROWS;
  localparam int unsigned FONT_ROWS    = 16;
  localparam int unsigned ROW_W        = $clog2(FONT_ROWS);
  localparam int unsigned COLOR_W      = 4;
  localparam logic        SYNC_POL_DEF = 1'b0;

  // Kept 12 bits wide so out-of-area cells can be detected before truncation to 11 bits.
  function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    return 12'(32'(row) * H_CHARS + 32'(col));
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register of Depth stages; every stage holds while en_i is low.
module vga_delay_line #(
  parameter int unsigned      Width    = 1,
  parameter int unsigned      Depth    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        stage_q[i] <= ResetVal;
      end
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(Depth); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/vga_text_fetch.sv
// Text-mode pixel pipeline: cell address -> char/attr word -> glyph row -> coloured pixel,
// with syncs and active delayed to stay aligned with pixel_o.
module vga_text_fetch
  import vga_pkg::*;
#(
  parameter int unsigned CURSOR_TOP = 14,
  parameter int unsigned BLINK_BITS = 6,
  parameter logic        SYNC_POL   = SYNC_POL_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pix_en_i,
  input  logic [9:0]         hcount_i,
  input  logic [9:0]         vcount_i,
  input  logic               active_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  input  logic [10:0]        cursor_addr_i,
  input  logic               cursor_en_i,
  output logic               ram_en_o,
  output logic [10:0]        ram_addr_o,
  input  logic [15:0]        ram_data_i,
  output logic               font_en_o,
  output logic [11:0]        font_addr_o,
  input  logic [7:0]         font_data_i,
  output logic [COLOR_W-1:0] pixel_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               active_o
);

  assign ram_en_o  = pix_en_i;
  assign font_en_o = pix_en_i;

  logic [11:0] addr_full;
  logic        addr_ok;

  assign addr_full = cell_addr(vcount_i[8:4], hcount_i[9:3]);
  assign addr_ok   = !vcount_i[9] && (addr_full < 12'(TEXT_WORDS));

  // Stage 1: cell address plus per-pixel position and flags.
  logic [2:0]       col1_q;
  logic [ROW_W-1:0] row1_q;
  logic             hit1_q;
  logic             ok1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ram_addr_o <= '0;
      col1_q     <= '0;
      row1_q     <= '0;
      hit1_q     <= 1'b0;
      ok1_q      <= 1'b0;
    end else if (pix_en_i) begin
      ram_addr_o <= addr_full[10:0];
      col1_q     <= hcount_i[2:0];
      row1_q     <= vcount_i[ROW_W-1:0];
      hit1_q     <= (addr_full[10:0] == cursor_addr_i);
      ok1_q      <= active_i && addr_ok;
    end
  end

  // Stages 2 and 3: font address from the fetched char, then glyph bit selection.
  logic [2:0]       col2;
  logic [ROW_W-1:0] row3;
  logic             hit3;
  logic             ok3;
  logic [7:0]       attr2_q;
  logic [7:0]       attr3_q;
  logic             bit3_q;

  vga_delay_line #(
    .Width    (3),
    .Depth    (1),
    .ResetVal ('0)
  ) u_col_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (pix_en_i),
    .d_i   (col1_q),
    .q_o   (col2)
  );

  vga_delay_line #(
    .Width    (ROW_W + 2),
    .Depth    (2),
    .ResetVal ('0)
  ) u_meta_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (pix_en_i),
    .d_i   ({row1_q, hit1_q, ok1_q}),
    .q_o   ({row3, hit3, ok3})
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      font_addr_o <= '0;
      attr2_q     <= '0;
      attr3_q     <= '0;
      bit3_q      <= 1'b0;
    end else if (pix_en_i) begin
      font_addr_o <= {ram_data_i[7:0], row1_q};
      attr2_q     <= ram_data_i[15:8];
      attr3_q     <= attr2_q;
      bit3_q      <= font_data_i[3'd7 - col2];
    end
  end

  vga_delay_line #(
    .Width    (3),
    .Depth    (4),
    .ResetVal ({1'b0, SYNC_POL, SYNC_POL})
  ) u_sync_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (pix_en_i),
    .d_i   ({active_i, vsync_i, hsync_i}),
    .q_o   ({active_o, vsync_o, hsync_o})
  );

  // Frame counter advances on each vsync departure from its inactive level.
  logic [BLINK_BITS-1:0] frame_q;
  logic                  vs_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_q   <= '0;
      vs_prev_q <= SYNC_POL;
    end else if (pix_en_i) begin
      vs_prev_q <= vsync_i;
      if ((vs_prev_q == SYNC_POL) && (vsync_i != SYNC_POL)) begin
        frame_q <= frame_q + 1'b1;
      end
    end
  end

  // Stage 4: colour mux.
  logic [COLOR_W-1:0] fg;
  logic [COLOR_W-1:0] bg;
  logic               glyph_bit;
  logic               cursor_on;
  logic [COLOR_W-1:0] pixel_d;

  always_comb begin
    fg        = attr3_q[3:0];
    bg        = {1'b0, attr3_q[6:4]};
    glyph_bit = bit3_q & ~(attr3_q[7] & frame_q[BLINK_BITS-1]);
    cursor_on = hit3 & cursor_en_i & (32'(row3) >= CURSOR_TOP) & frame_q[BLINK_BITS-2];
    pixel_d   = '0;
    if (!ok3) begin
      pixel_d = '0;
    end else if (cursor_on) begin
      pixel_d = fg;
    end else begin
      pixel_d = glyph_bit ? fg : bg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pixel_o <= '0;
    end else if (pix_en_i) begin
      pixel_o <= pixel_d;
    end
  end

endmodule

// File: tb/tb_vga_text_fetch.sv
// Directed bench for vga_text_fetch: reset, addressing, pixel path, stalls, blink and cursor.
module tb_vga_text_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        active;
  logic        hsync;
  logic        vsync;
  logic [10:0] cursor_addr;
  logic        cursor_en;
  logic        ram_en;
  logic [10:0] ram_addr;
  logic [15:0] ram_data;
  logic        font_en;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [3:0]  pixel;
  logic        hsync_out;
  logic        vsync_out;
  logic        active_out;

  logic [15:0] text_mem [2048];
  logic [7:0]  font_mem [4096];

  assign ram_data  = text_mem[ram_addr];
  assign font_data = font_mem[font_addr];

  always #5 clk = ~clk;

  vga_text_fetch dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pix_en_i      (pix_en),
    .hcount_i      (hcount),
    .vcount_i      (vcount),
    .active_i      (active),
    .hsync_i       (hsync),
    .vsync_i       (vsync),
    .cursor_addr_i (cursor_addr),
    .cursor_en_i   (cursor_en),
    .ram_en_o      (ram_en),
    .ram_addr_o    (ram_addr),
    .ram_data_i    (ram_data),
    .font_en_o     (font_en),
    .font_addr_o   (font_addr),
    .font_data_i   (font_data),
    .pixel_o       (pixel),
    .hsync_o       (hsync_out),
    .vsync_o       (vsync_out),
    .active_o      (active_out)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic [10:0] exp_addr;
  } addr_vec_t;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       act;
    logic       hs;
    logic [3:0] exp_pix;
  } pix_vec_t;

  localparam int NPIX = 15;
  addr_vec_t atab [7];
  pix_vec_t  ptab [NPIX];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [9:0] h, input logic [9:0] v,
                       input logic act, input logic hs, input logic vs);
    pix_en = en;
    hcount = h;
    vcount = v;
    active = act;
    hsync  = hs;
    vsync  = vs;
  endtask

  task automatic strobe_entry(input int i);
    if (i < NPIX) drive(1'b1, ptab[i].h, ptab[i].v, ptab[i].act, ptab[i].hs, 1'b0);
    else drive(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // mode 0: every clock a strobe; 1: half duty; 2: random gaps with junk inputs.
  task automatic run_table(input int mode, input string tag);
    for (int i = 0; i < NPIX + 3; i++) begin
      int gaps;
      gaps = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
      for (int g = 0; g < gaps; g++) begin
        drive(1'b0, 10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        tick();
        if (i >= 4) check($sformatf("%s hold%0d pix", tag, i), 32'(pixel), 32'(ptab[i-4].exp_pix));
      end
      strobe_entry(i);
      if (i >= 3) begin
        check($sformatf("%s e%0d pix", tag, i - 3), 32'(pixel), 32'(ptab[i-3].exp_pix));
        check($sformatf("%s e%0d hs", tag, i - 3), 32'(hsync_out), 32'(ptab[i-3].hs));
        check($sformatf("%s e%0d act", tag, i - 3), 32'(active_out), 32'(ptab[i-3].act));
      end
    end
  endtask

  task automatic draw_check(input string name, input logic [9:0] h0, input logic [9:0] v,
                            input logic [31:0] exp);
    for (int i = 0; i < 11; i++) begin
      if (i < 8) drive(1'b1, h0 + 10'(i), v, 1'b1, 1'b0, 1'b0);
      else drive(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      tick();
      if (i >= 3) check($sformatf("%s px%0d", name, i - 3), 32'(pixel), 32'(exp[(10-i)*4 +: 4]));
    end
  endtask

  task automatic vs_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    logic [31:0] glyph_a;
    logic [31:0] glyph_b;
    glyph_a = 32'h111EE111;
    glyph_b = 32'h0707;

    for (int i = 0; i < 2048; i++) text_mem[i] = 16'h0000;
    for (int i = 0; i < 4096; i++) font_mem[i] = 8'h00;
    text_mem[0]    = 16'h1E41;
    text_mem[1]    = 16'h7042;
    text_mem[2]    = 16'h9F41;
    text_mem[4]    = 16'h1E41;
    text_mem[5]    = 16'h1E41;
    text_mem[1999] = 16'h2C41;
    text_mem[2000] = 16'h1E41;
    font_mem[{8'h41, 4'd0}]  = 8'b0001_1000;
    font_mem[{8'h41, 4'd13}] = 8'b1000_0001;
    font_mem[{8'h42, 4'd0}]  = 8'b1010_0000;

    atab[0] = '{10'd637, 10'd399, 11'd1999};
    atab[1] = '{10'd8,   10'd16,  11'd81};
    atab[2] = '{10'd0,   10'd0,   11'd0};
    atab[3] = '{10'd639, 10'd0,   11'd79};
    atab[4] = '{10'd0,   10'd399, 11'd1920};
    atab[5] = '{10'd100, 10'd200, 11'd972};
    atab[6] = '{10'd15,  10'd17,  11'd81};

    for (int i = 0; i < 8; i++) ptab[i] = '{10'(i), 10'd0, 1'b1, (i == 3), glyph_a[(7-i)*4 +: 4]};
    for (int i = 0; i < 4; i++) ptab[8+i] = '{10'(8 + i), 10'd0, 1'b1, 1'b0, glyph_b[(3-i)*4 +: 4]};
    ptab[12] = '{10'd12,  10'd0,   1'b0, 1'b1, 4'd0};
    ptab[13] = '{10'd3,   10'd400, 1'b1, 1'b0, 4'd0};  // cell 2000: off-screen, masked
    ptab[14] = '{10'd637, 10'd399, 1'b1, 1'b0, 4'd2};

    cursor_addr = 11'd5;
    cursor_en   = 1'b0;

    // Reset with junk inputs.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    check("rst pixel", 32'(pixel), 32'd0);
    check("rst active", 32'(active_out), 32'd0);
    check("rst hsync", 32'(hsync_out), 32'd0);
    check("rst vsync", 32'(vsync_out), 32'd0);
    check("rst ram_addr", 32'(ram_addr), 32'd0);
    check("rst font_addr", 32'(font_addr), 32'd0);
    rst = 1'b0;
    drive(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("en low ram_en", 32'(ram_en), 32'd0);
    check("en low font_en", 32'(font_en), 32'd0);

    for (int i = 0; i < 7; i++) begin
      drive(1'b1, atab[i].h, atab[i].v, 1'b1, 1'b0, 1'b0);
      tick();
      check($sformatf("addr%0d", i), 32'(ram_addr), 32'(atab[i].exp_addr));
    end
    check("en high ram_en", 32'(ram_en), 32'd1);
    check("en high font_en", 32'(font_en), 32'd1);

    run_table(0, "full");
    run_table(1, "half");
    run_table(2, "gaps");

    // Reset in the middle of a line, while a foreground pixel and hsync are on the outputs.
    for (int i = 0; i < 7; i++) strobe_entry(i);
    check("pre-rst pix", 32'(pixel), 32'd14);
    rst = 1'b1;
    drive(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    tick();
    check("midrst pixel", 32'(pixel), 32'd0);
    check("midrst hsync", 32'(hsync_out), 32'd0);
    check("midrst active", 32'(active_out), 32'd0);
    check("midrst ram_addr", 32'(ram_addr), 32'd0);
    rst = 1'b0;
    run_table(0, "after rst");

    // Blink: frame counter 0 -> 32 -> 64 (wraps to 0).
    draw_check("blink f0", 10'd16, 10'd0, 32'h111FF111);
    drive(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check("vs dly0", 32'(vsync_out), 32'd0);
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      tick();
      check($sformatf("vs dly%0d", i), 32'(vsync_out), (i == 3) ? 32'd1 : 32'd0);
    end
    vs_pulses(31);
    draw_check("blink f32", 10'd16, 10'd0, 32'h11111111);
    vs_pulses(32);
    draw_check("blink f64", 10'd16, 10'd0, 32'h111FF111);

    // Cursor at cell 5 with frame counter 16 (cursor phase on, blink phase off).
    vs_pulses(16);
    cursor_en = 1'b1;
    draw_check("cur r14", 10'd40, 10'd14, 32'hEEEEEEEE);
    draw_check("cur r15", 10'd40, 10'd15, 32'hEEEEEEEE);
    draw_check("cur r13", 10'd40, 10'd13, 32'hE111111E);
    draw_check("cur r0", 10'd40, 10'd0, 32'h111EE111);
    draw_check("cur other cell", 10'd32, 10'd14, 32'h11111111);
    cursor_en = 1'b0;
    draw_check("cur disabled", 10'd40, 10'd14, 32'h11111111);
    cursor_en = 1'b1;
    vs_pulses(16);
    draw_check("cur phase off", 10'd40, 10'd14, 32'h11111111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
